// File: rtl/nios_sys_buttons.sv
// Avalon-MM button/switch port: per-pin synchronizer and debouncer, edge capture
// with selectable edge mode, and a masked level interrupt.
module nios_sys_buttons #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 12000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK  = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd2;
  localparam logic [1:0] ADDR_EDGEMODE = 2'd3;

  logic [WIDTH-1:0]            sync1;
  logic [WIDTH-1:0]            sync2;
  logic [WIDTH-1:0]            stable;
  logic [WIDTH-1:0]            stable_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt;
  logic [WIDTH-1:0]            irq_mask;
  logic [WIDTH-1:0]            edge_cap;
  logic [1:0]                  edge_mode;

  logic                        wr_en_c;
  logic [WIDTH-1:0]            cap_clr_c;
  logic [WIDTH-1:0]            edge_evt_c;

  // Two-flop synchronizer for the asynchronous pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Per-pin debounce: accept a new level only after it persists for the full window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
      cnt    <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign wr_en_c   = chipselect & ~write_n;
  assign cap_clr_c = (wr_en_c && (address == ADDR_EDGECAP)) ? WIDTH'(writedata) : '0;

  // Edge qualification against the one-cycle-delayed debounced level
  always_comb begin
    edge_evt_c = '0;
    unique case (edge_mode)
      2'd0:    edge_evt_c = stable & ~stable_d;
      2'd1:    edge_evt_c = ~stable & stable_d;
      default: edge_evt_c = stable ^ stable_d;
    endcase
  end

  // Control registers; a capture event beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_d  <= '0;
      irq_mask  <= '0;
      edge_cap  <= '0;
      edge_mode <= '0;
    end else begin
      stable_d <= stable;
      edge_cap <= (edge_cap & ~cap_clr_c) | edge_evt_c;
      if (wr_en_c) begin
        unique case (address)
          ADDR_IRQMASK:  irq_mask  <= WIDTH'(writedata);
          ADDR_EDGEMODE: edge_mode <= writedata[1:0];
          default:       ;
        endcase
      end
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_DATA:     readdata = 32'(stable);
      ADDR_IRQMASK:  readdata = 32'(irq_mask);
      ADDR_EDGECAP:  readdata = 32'(edge_cap);
      ADDR_EDGEMODE: readdata = 32'(edge_mode);
      default:       readdata = '0;
    endcase
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_nios_sys_buttons.sv
// Bench for nios_sys_buttons: directed vector table, hand sequences for reset
// and address-0 writes, then random traffic against a window-based reference model.
module tb_nios_sys_buttons;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEB   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int n_checks = 0;
  int n_errors = 0;

  nios_sys_buttons #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: pins delayed two samples, a level is accepted when the last
  // DEB synchronized samples all agree and differ from the accepted level.
  logic [7:0] m_p1, m_p2, m_st, m_sd, m_mask, m_cap;
  logic [1:0] m_mode;
  logic [7:0] m_hist [DEB];
  logic       bus_wr;

  assign bus_wr = chipselect && !write_n;

  function automatic logic [7:0] next_stable(input logic [7:0] st, input logic [7:0] newest,
                                             input logic [7:0] h [DEB]);
    logic [7:0] r;
    r = st;
    for (int i = 0; i < 8; i++) begin
      int ones;
      ones = int'(newest[i]);
      for (int k = 0; k < int'(DEB) - 1; k++) ones += int'(h[k][i]);
      if (ones == int'(DEB) && !st[i]) r[i] = 1'b1;
      else if (ones == 0 && st[i]) r[i] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [7:0] events(input logic [1:0] mode, input logic [7:0] now, input logic [7:0] prev);
    if (mode == 2'd0) return now & ~prev;
    if (mode == 2'd1) return prev & ~now;
    return now ^ prev;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_p1 <= '0; m_p2 <= '0; m_st <= '0; m_sd <= '0;
      m_mask <= '0; m_cap <= '0; m_mode <= '0;
      for (int k = 0; k < int'(DEB); k++) m_hist[k] <= '0;
    end else begin
      m_p1 <= in_port;
      m_p2 <= m_p1;
      m_hist[0] <= m_p2;
      for (int k = 1; k < int'(DEB); k++) m_hist[k] <= m_hist[k-1];
      m_st <= next_stable(m_st, m_p2, m_hist);
      m_sd <= m_st;
      m_cap <= (m_cap & ~((bus_wr && address == 2'd2) ? writedata[7:0] : 8'h00))
               | events(m_mode, m_st, m_sd);
      if (bus_wr && address == 2'd1) m_mask <= writedata[7:0];
      if (bus_wr && address == 2'd3) m_mode <= writedata[1:0];
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_st};
      2'd1:    return {24'h0, m_mask};
      2'd2:    return {24'h0, m_cap};
      default: return {30'h0, m_mode};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // One clock, then compare the DUT against the model away from the edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("model_rd", readdata, model_rd(address));
    chk("model_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
  endtask

  typedef struct {
    logic [7:0]  pins;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] pins, input logic wr, input logic [1:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_irq);
    vec_t v;
    v.pins = pins; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0] pins;

    // Accept 0x01 after DEB+2 edges, capture one edge later, then clear
    for (int k = 1; k <= 5; k++) add(8'h01, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    add(8'h01, 1'b0, 2'd0, 32'h0, 32'h1, 1'b0);
    add(8'h01, 1'b0, 2'd2, 32'h0, 32'h1, 1'b0);
    add(8'h01, 1'b1, 2'd2, 32'h1, 32'h0, 1'b0);
    // Three-cycle glitch on bit 3 is rejected
    for (int k = 0; k < 3; k++) add(8'h09, 1'b0, 2'd0, 32'h0, 32'h1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      add(8'h01, 1'b0, 2'd0, 32'h0, 32'h1, 1'b0);
      add(8'h01, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0);
    end
    // Falling-edge mode with bit-1 mask
    add(8'h01, 1'b1, 2'd1, 32'h2, 32'h2, 1'b0);
    add(8'h01, 1'b1, 2'd3, 32'h1, 32'h1, 1'b0);
    for (int k = 1; k <= 10; k++) add(8'h03, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0);
    for (int k = 1; k <= 10; k++)
      add(8'h01, 1'b0, 2'd2, 32'h0, (k >= 7) ? 32'h2 : 32'h0, k >= 7);
    add(8'h01, 1'b1, 2'd2, 32'h2, 32'h0, 1'b0);
    // Any-edge mode: clear write on the exact set cycle loses
    add(8'h01, 1'b1, 2'd3, 32'h2, 32'h2, 1'b0);
    add(8'h01, 1'b1, 2'd1, 32'hFF, 32'hFF, 1'b0);
    for (int k = 1; k <= 6; k++) add(8'h00, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0);
    add(8'h00, 1'b1, 2'd2, 32'h1, 32'h1, 1'b1);
    add(8'h00, 1'b0, 2'd2, 32'h0, 32'h1, 1'b1);
    add(8'h00, 1'b1, 2'd2, 32'h1, 32'h0, 1'b0);

    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_port = '0;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      chk($sformatf("reset_rd%0d", a), readdata, 32'h0);
    end
    chk("reset_irq", {31'h0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int r = 0; r < vecs.size(); r++) begin
      in_port = vecs[r].pins;
      chipselect = 1'b1;
      write_n = !vecs[r].wr;
      address = vecs[r].addr;
      writedata = vecs[r].wdata;
      tick();
      chk($sformatf("vec%0d_rd", r), readdata, vecs[r].exp_rd);
      chk($sformatf("vec%0d_irq", r), {31'h0, irq}, {31'h0, vecs[r].exp_irq});
    end
    write_n = 1'b1;

    // Reset while 0xFF is mid-debounce
    in_port = 8'hFF; address = 2'd0;
    repeat (3) tick();
    reset = 1'b1;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      chk($sformatf("midrst_rd%0d", a), readdata, 32'h0);
    end
    chk("midrst_irq", {31'h0, irq}, 32'h0);
    tick();
    reset = 1'b0;
    address = 2'd0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 7) address = 2'd2;
      tick();
      if (k < 7) chk($sformatf("rel_data_e%0d", k), readdata, (k == 6) ? 32'hFF : 32'h0);
      else chk("rel_edgecap", readdata, 32'hFF);
    end

    // Writes to DATA are ignored; upper readdata bits are zero everywhere
    address = 2'd0; writedata = 32'hA5; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chk("data_after_wr", readdata, 32'hFF);
    write_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      chk($sformatf("upper_zero%0d", a), {8'h0, readdata[31:8]}, 32'h0);
    end

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      pins = in_port;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 5) == 0) pins[b] = ~pins[b];
      in_port = pins;
      address = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 3) != 0);
      write_n = ($urandom_range(0, 7) != 0);
      writedata = $urandom;
      if (c == 1500) reset = 1'b1;
      tick();
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nios_sys_buttons.md
NIOS_SYS_BUTTONS -- requirements
Module: nios_sys_buttons

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of input pins.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 12000: cycles an input must stay stable before acceptance, legal range 1 to 65535.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port address, input, 2 bits: Avalon-MM slave word address.
REQ-006 The block SHALL have port chipselect, input, 1 bit: slave select.
REQ-007 The block SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-008 The block SHALL have port writedata, input, 32 bits: write data.
REQ-009 The block SHALL have port in_port, input, WIDTH bits: asynchronous external button/switch pins.
REQ-010 The block SHALL have port readdata, output, 32 bits: read data, zero-wait, combinational from address.
REQ-011 The block SHALL have port irq, output, 1 bit: level interrupt to the processor.

Function
REQ-012 in_port SHALL pass through a two-flop synchronizer (sync1, sync2) per bit before any other use.
REQ-013 Each bit SHALL have a debounce counter and a stable register with the following behaviour.
- Counter clears when sync2 equals stable.
- Otherwise the counter increments.
- When the counter equals DEBOUNCE_CYCLES-1 and sync2 differs from stable, stable loads sync2 and the counter clears.
REQ-014 A level held on in_port SHALL appear in stable exactly DEBOUNCE_CYCLES+2 rising edges after it is first sampled.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 SHALL never change stable.
REQ-016 Register map (word addresses):
- 0 = DATA: read-only, stable, zero-extended.
- 1 = IRQMASK: read/write, WIDTH bits.
- 2 = EDGECAP: read, write-1-to-clear.
- 3 = EDGEMODE: read/write, 2 bits, writedata[1:0].
REQ-017 A write SHALL occur on a cycle with chipselect=1 and write_n=0; writes to address 0 SHALL be ignored.
REQ-018 Unused readdata bits SHALL read 0.
REQ-019 The block SHALL keep a registered copy stable_d of stable; an edge event for bit i is defined by EDGEMODE:
- 0 = rising (stable_d=0, stable=1).
- 1 = falling.
- 2 or 3 = any change.
REQ-020 An edge event SHALL set EDGECAP[i] on the same clock edge at which stable_d updates, i.e. one cycle after stable changes.
REQ-021 Writing EDGECAP with writedata bit i = 1 SHALL clear bit i; bits written 0 SHALL be unchanged.
REQ-022 If a set event and a clear write hit the same bit on the same cycle, set SHALL win.
REQ-023 irq SHALL equal the OR over i of (EDGECAP[i] AND IRQMASK[i]), combinational from registers, with no added latency.
REQ-024 Changing EDGEMODE SHALL neither clear EDGECAP nor reset the debounce counters.
REQ-025 Debounce counters SHALL be sized to hold DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-026 While reset=1, the following SHALL hold, asynchronously:
- sync1, sync2, stable, stable_d = 0.
- Counters = 0.
- IRQMASK = 0, EDGECAP = 0, EDGEMODE = 0.
- irq = 0.
REQ-027 Assertion of reset mid-debounce SHALL discard the partial count; after release, an in_port already high SHALL be accepted DEBOUNCE_CYCLES+2 edges later and SHALL generate a rising edge event.

Verification (bench uses WIDTH=8, DEBOUNCE_CYCLES=4)
REQ-028 Drive in_port 0x00->0x01 and hold; expected response:
- DATA reads 0x00000001 exactly 6 edges later.
- EDGECAP reads 0x01 one edge after that.
REQ-029 Pulse in_port[3] high for 3 cycles, then low; expected response:
- DATA stays 0x00.
- EDGECAP stays 0x00.
- irq stays 0.
REQ-030 Write IRQMASK=0x02 and EDGEMODE=1, then drive in_port[1] high and later low (each held 10 cycles); expected response:
- EDGECAP bit1 sets only on the falling transition.
- irq goes 1.
- Writing EDGECAP=0x02 returns irq to 0.
REQ-031 With EDGEMODE=2 and IRQMASK=0xFF, issue the EDGECAP=0x01 clear write on the exact cycle bit0's edge event sets it; expected response: EDGECAP bit0 remains 1 and irq remains 1.
REQ-032 Assert reset for 1 cycle while in_port=0xFF is mid-debounce, then release; expected response:
- All registers read 0 and irq=0 during reset.
- DATA=0xFF exactly 6 edges after release.
- EDGECAP=0xFF one edge later.
REQ-033 Write address 0 with 0xA5, then read addresses 0 to 3; expected response: DATA is unaffected and the upper 24 readdata bits are 0 at every address.
